// File: rtl/alu_serial_seq.sv
// Bit-serial ALU: and / or / add / set-less-than, one bit per clock, LSB first.
// A start in IDLE latches operands; WIDTH RUN cycles later the result and
// flags are valid and done pulses for one cycle in DONE.
module alu_serial_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             a_invert,
    input  logic             b_invert,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             co
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_ADD = 2'b10,
        OP_SLT = 2'b11
    } op_t;

    state_t           state;
    state_t           state_next;
    logic             accept;

    logic [WIDTH-1:0] a_lat;
    logic [WIDTH-1:0] b_lat;
    logic             a_inv_lat;
    logic             b_inv_lat;
    op_t              op_lat;

    logic             carry;
    logic [IDX_W-1:0] bit_idx;
    logic             last_bit;

    logic             ai;
    logic             bi;
    logic             sum;
    logic             carry_next;
    logic             bit_val;
    logic [WIDTH-1:0] result_next;

    // State register; reset wins over any pending transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus busy/done/accept strobes.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    accept     = 1'b1;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (last_bit) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Capture the request so later input changes cannot disturb a running op.
    always_ff @(posedge clk) begin
        // NOTE: these holding registers carry no reset; they are read only in RUN, which is entered solely through a start that loads them.
        if (accept) begin
            a_lat     <= a;
            b_lat     <= b;
            a_inv_lat <= a_invert;
            b_inv_lat <= b_invert;
            op_lat    <= op_t'(op);
        end
    end

    // One-bit full-adder slice on the current bit position.
    assign last_bit   = (bit_idx == LAST_IDX);
    assign ai         = a_lat[bit_idx] ^ a_inv_lat;
    assign bi         = b_lat[bit_idx] ^ b_inv_lat;
    assign sum        = ai ^ bi ^ carry;
    assign carry_next = (ai & bi) | (ai & carry) | (bi & carry);

    // Merge this step's result bit; slt drops the sign of the difference into bit 0 on the last step.
    always_comb begin
        bit_val     = 1'b0;
        result_next = result;
        case (op_lat)
            OP_AND:  bit_val = ai & bi;
            OP_OR:   bit_val = ai | bi;
            OP_ADD:  bit_val = sum;
            default: bit_val = 1'b0;
        endcase
        result_next[bit_idx] = bit_val;
        if (op_lat == OP_SLT && last_bit) begin
            result_next[0] = sum;
        end
    end

    // Bit-step sequencing, carry chain and final flag capture.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples the values from before the edge.
        if (reset) begin
            carry    <= 1'b0;
            bit_idx  <= '0;
            result   <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            co       <= 1'b0;
        end else if (accept) begin
            carry   <= b_invert;
            bit_idx <= '0;
        end else if (state == S_RUN) begin
            carry  <= carry_next;
            result <= result_next;
            if (last_bit) begin
                bit_idx  <= '0;
                zero     <= (result_next == '0);
                co       <= carry_next;
                overflow <= (op_lat == OP_ADD) && (carry ^ carry_next);
            end else begin
                bit_idx <= bit_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Bench for alu_serial_seq: directed vectors, a word-level reference model
// checked every cycle, and literal expectations per vector.
module tb_alu_serial_seq;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             a_invert;
    logic             b_invert;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             co;

    alu_serial_seq #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a_invert (a_invert),
        .b_invert (b_invert),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .zero     (zero),
        .overflow (overflow),
        .co       (co)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit chk_en    = 1'b0;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Word-level reference: whole-operand arithmetic, no bit stepping.
    typedef struct {
        logic [WIDTH-1:0] r;
        logic             z;
        logic             c;
        logic             v;
    } res_t;

    function automatic res_t alu_ref(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                     input logic ai, input logic bi, input logic [1:0] o);
        res_t             res;
        logic [WIDTH-1:0] aa;
        logic [WIDTH-1:0] bb;
        logic [WIDTH:0]   full;
        aa   = ai ? ~av : av;
        bb   = bi ? ~bv : bv;
        full = {1'b0, aa} + {1'b0, bb} + {{WIDTH{1'b0}}, bi};
        res.c = full[WIDTH];
        res.v = 1'b0;
        case (o)
            2'b00: res.r = aa & bb;
            2'b01: res.r = aa | bb;
            2'b10: begin
                res.r = full[WIDTH-1:0];
                res.v = (aa[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != aa[WIDTH-1]);
            end
            default: res.r = {{(WIDTH-1){1'b0}}, full[WIDTH-1]};
        endcase
        res.z = (res.r == '0);
        return res;
    endfunction

    // Model timing: cycles elapsed since the accepting edge, -1 when idle.
    int               cnt = -1;
    logic [WIDTH-1:0] m_a;
    logic [WIDTH-1:0] m_b;
    logic             m_ai;
    logic             m_bi;
    logic [1:0]       m_op;
    logic [WIDTH-1:0] exp_result = '0;
    logic             exp_zero   = 1'b0;
    logic             exp_ovf    = 1'b0;
    logic             exp_co     = 1'b0;
    logic             exp_busy   = 1'b0;
    logic             exp_done   = 1'b0;

    always @(posedge clk) begin
        res_t res;
        if (reset) begin
            cnt        = -1;
            exp_result = '0;
            exp_zero   = 1'b0;
            exp_ovf    = 1'b0;
            exp_co     = 1'b0;
        end else if (cnt < 0) begin
            if (start) begin
                m_a  = a;
                m_b  = b;
                m_ai = a_invert;
                m_bi = b_invert;
                m_op = op;
                cnt  = 0;
            end
        end else begin
            cnt++;
            if (cnt == WIDTH) begin
                res        = alu_ref(m_a, m_b, m_ai, m_bi, m_op);
                exp_result = res.r;
                exp_zero   = res.z;
                exp_ovf    = res.v;
                exp_co     = res.c;
            end else if (cnt == WIDTH + 1) begin
                cnt = -1;
            end
        end
        exp_busy = (cnt >= 0);
        exp_done = (cnt == WIDTH);
    end

    // Compare DUT against the model every cycle; data only when it is defined.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", busy, exp_busy);
            check("done", done, exp_done);
            if (!exp_busy || exp_done) begin
                check("result", result, exp_result);
                check("zero", zero, exp_zero);
                check("overflow", overflow, exp_ovf);
                check("co", co, exp_co);
            end
        end
    end

    // Issue one op, scramble inputs after acceptance, optionally poke start mid-run,
    // then require done after exactly WIDTH edges and the literal results.
    task automatic run_op(input string name, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic ai, input logic bi, input logic [1:0] o, input int poke,
                          input logic [WIDTH-1:0] lr, input logic lz, input logic lc, input logic lv);
        int lat;
        @(negedge clk);
        a        = av;
        b        = bv;
        a_invert = ai;
        b_invert = bi;
        op       = o;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        a        = $urandom;
        b        = $urandom;
        a_invert = ~ai;
        b_invert = ~bi;
        op       = ~o;
        lat      = 0;
        while (lat < WIDTH + 4) begin
            @(negedge clk);
            lat++;
            start = (lat == poke);
            if (done) break;
        end
        start = 1'b0;
        check({name, "_latency"}, lat, WIDTH);
        check({name, "_result"}, result, lr);
        check({name, "_zero"}, zero, lz);
        check({name, "_co"}, co, lc);
        check({name, "_ovf"}, overflow, lv);
        check({name, "_model"}, exp_result, lr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_done;
        reset    = 1'b1;
        start    = 1'b1;
        a        = '0;
        b        = '0;
        a_invert = 1'b0;
        b_invert = 1'b0;
        op       = 2'b00;
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy", busy, 0);
        check("rst_result", result, 0);
        reset = 1'b0;
        start = 1'b0;

        run_op("add_5_7",   32'd5,        32'd7,        1'b0, 1'b0, 2'b10, -1, 32'd12,       1'b0, 1'b0, 1'b0);
        run_op("sub_7_7",   32'd7,        32'd7,        1'b0, 1'b1, 2'b10, -1, 32'd0,        1'b1, 1'b1, 1'b0);
        run_op("slt_3_5",   32'd3,        32'd5,        1'b0, 1'b1, 2'b11, -1, 32'd1,        1'b0, 1'b0, 1'b0);
        run_op("slt_5_3",   32'd5,        32'd3,        1'b0, 1'b1, 2'b11, -1, 32'd0,        1'b1, 1'b1, 1'b0);
        run_op("add_ovf",   32'h7FFFFFFF, 32'd1,        1'b0, 1'b0, 2'b10, -1, 32'h80000000, 1'b0, 1'b0, 1'b1);
        run_op("and_max",   32'h7FFFFFFF, 32'd1,        1'b0, 1'b0, 2'b00, -1, 32'd1,        1'b0, 1'b0, 1'b0);
        run_op("nor",       32'hF0F0F0F0, 32'h0F0F0F0F, 1'b1, 1'b1, 2'b00, -1, 32'd0,        1'b1, 1'b1, 1'b0);
        run_op("or_poke",   32'h12340000, 32'h00005678, 1'b0, 1'b0, 2'b01, 10, 32'h12345678, 1'b0, 1'b0, 1'b0);
        run_op("add_neg",   32'h80000000, 32'h80000000, 1'b0, 1'b0, 2'b10, -1, 32'd0,        1'b1, 1'b1, 1'b1);
        run_op("sub_ovf",   32'h80000000, 32'd1,        1'b0, 1'b1, 2'b10, -1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1);

        // Abandoned op: ignored start at bit 10, reset (with start) at bit 20.
        @(negedge clk);
        a        = 32'd5;
        b        = 32'd7;
        a_invert = 1'b0;
        b_invert = 1'b0;
        op       = 2'b10;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        start = 1'b1;
        a     = '1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        check("abort_zero", zero, 0);
        check("abort_ovf", overflow, 0);
        check("abort_co", co, 0);
        saw_done = 1'b0;
        repeat (WIDTH + 2) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", saw_done, 0);

        run_op("fresh",     32'd100,      32'd23,       1'b0, 1'b0, 2'b10, -1, 32'd123,      1'b0, 1'b0, 1'b0);
        run_op("b2b_slt",   32'hFFFFFFFF, 32'd1,        1'b0, 1'b1, 2'b11, -1, 32'd1,        1'b0, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
